// File: rtl/move_seq_to_ssd_pkg.sv
// Shared character codes and sizing helper for the move-sequence to seven-segment encoder.
// The default table maps slot 4..0 to r, d, l, u, c.
package move_seq_to_ssd_pkg;

  localparam logic [7:0] CHAR_R     = 8'h72;
  localparam logic [7:0] CHAR_D     = 8'h64;
  localparam logic [7:0] CHAR_L     = 8'h6C;
  localparam logic [7:0] CHAR_U     = 8'h75;
  localparam logic [7:0] CHAR_C     = 8'h63;
  localparam logic [7:0] CHAR_BLANK = 8'h20;

  localparam logic [39:0] DEFAULT_CHAR_TABLE = {CHAR_R, CHAR_D, CHAR_L, CHAR_U, CHAR_C};

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/move_seq_to_ssd_prio_pick.sv
// Combinational find-first-set over the pending move vector.
// MSB_FIRST selects whether the highest or the lowest set bit wins.
module move_prio_pick
  import move_seq_to_ssd_pkg::*;
#(
  parameter int N_MOVES   = 5,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IDX_W     = idx_width(N_MOVES)
) (
  input  logic [N_MOVES-1:0] vec,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // The last match seen in the loop wins, so the loop runs toward the priority end.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N_MOVES; i++) begin
        if (vec[i]) begin
          found = 1'b1;
          idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int i = N_MOVES - 1; i >= 0; i--) begin
        if (vec[i]) begin
          found = 1'b1;
          idx   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/move_seq_to_ssd.sv
// Encodes a multi-hot move vector into N_DIGITS display characters, one per cycle,
// with a fixed start-to-ready latency of N_DIGITS+2 clock edges.
module move_seq_to_ssd
  import move_seq_to_ssd_pkg::*;
#(
  parameter int                N_MOVES    = 5,
  parameter int                N_DIGITS   = 4,
  parameter int                CHAR_W     = 8,
  parameter logic [CHAR_W-1:0] BLANK_CHAR = CHAR_W'(CHAR_BLANK),
  parameter bit                MSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_MOVES-1:0]            moves,
  input  logic [N_MOVES*CHAR_W-1:0]     char_table,
  output logic [N_DIGITS*CHAR_W-1:0]    ssd_digits,
  output logic                          ready,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(N_MOVES+1)-1:0]  count
);

  localparam int                         IDX_W      = idx_width(N_MOVES);
  localparam int                         SC_W       = idx_width(N_DIGITS);
  localparam logic [SC_W-1:0]            LAST_SHIFT = SC_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS*CHAR_W-1:0] BLANK_ALL  = {N_DIGITS{BLANK_CHAR}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                     state;
  state_t                     state_d;
  logic [N_MOVES-1:0]         moves_smp;
  logic [N_MOVES-1:0]         pending;
  logic [SC_W-1:0]            sh_cnt;
  logic                       pick_found;
  logic [IDX_W-1:0]           pick_idx;
  logic [CHAR_W-1:0]          shift_char;
  logic [N_DIGITS*CHAR_W-1:0] digits_next;
  logic                       last_shift;

  move_prio_pick #(
    .N_MOVES   (N_MOVES),
    .MSB_FIRST (MSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_pick (
    .vec   (pending),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign last_shift = (sh_cnt == LAST_SHIFT);

  // New character enters at the top digit; after N_DIGITS shifts the first pick sits in digit 0.
  always_comb begin
    shift_char  = BLANK_CHAR;
    if (pick_found) begin
      shift_char = char_table[int'(pick_idx)*CHAR_W +: CHAR_W];
    end
    digits_next = (N_DIGITS*CHAR_W)'({shift_char, ssd_digits} >> CHAR_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // A start request overrides every state, including the final shift.
  always_comb begin
    state_d = state;
    if (start) begin
      state_d = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE:  state_d = ST_IDLE;
        ST_LOAD:  state_d = ST_SHIFT;
        ST_SHIFT: if (last_shift) state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      moves_smp  <= '0;
      pending    <= '0;
      sh_cnt     <= '0;
      ssd_digits <= BLANK_ALL;
      ready      <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      count      <= '0;
    end else if (start) begin
      moves_smp <= moves;
      ready     <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_LOAD: begin
          pending    <= moves_smp;
          ssd_digits <= BLANK_ALL;
          count      <= '0;
          ready      <= 1'b0;
          overflow   <= 1'b0;
          busy       <= 1'b1;
          sh_cnt     <= '0;
        end
        ST_SHIFT: begin
          ssd_digits <= digits_next;
          sh_cnt     <= sh_cnt + 1'b1;
          if (pick_found) begin
            pending[pick_idx] <= 1'b0;
            count             <= count + 1'b1;
          end
        end
        ST_DONE: begin
          // First DONE cycle publishes the result; later cycles just hold it.
          if (!ready) begin
            ready    <= 1'b1;
            busy     <= 1'b0;
            overflow <= |pending;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_seq_to_ssd.sv
// Bench for move_seq_to_ssd: fixed vectors, restart/reset corner cases and random
// moves/tables against a priority-list reference model, on MSB- and LSB-first instances.
module tb_move_seq_to_ssd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  moves;
  logic [39:0] char_table;
  logic [31:0] ssd_m, ssd_l;
  logic        ready_m, busy_m, ovf_m;
  logic        ready_l, busy_l, ovf_l;
  logic [2:0]  cnt_m, cnt_l;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [39:0] DEF_TABLE = 40'h72_64_6C_75_63;

  always #5 clk = ~clk;

  move_seq_to_ssd #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .start(start), .moves(moves), .char_table(char_table),
    .ssd_digits(ssd_m), .ready(ready_m), .busy(busy_m), .overflow(ovf_m), .count(cnt_m)
  );

  move_seq_to_ssd #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .start(start), .moves(moves), .char_table(char_table),
    .ssd_digits(ssd_l), .ready(ready_l), .busy(busy_l), .overflow(ovf_l), .count(cnt_l)
  );

  typedef struct {
    logic [4:0]  mv;
    bit          lsb;
    logic [31:0] dig;
    int          cnt;
    bit          ovf;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Priority list of set bits, first N_DIGITS kept, digit k gets the k-th move's char.
  function automatic void model(input logic [4:0] mv, input logic [39:0] tbl, input bit msb,
                                output logic [31:0] dig, output int cnt, output bit ovf);
    int order[$];
    order.delete();
    for (int k = 0; k < 5; k++) begin
      int i;
      i = msb ? 4 - k : k;
      if (mv[i]) order.push_back(i);
    end
    dig = {4{8'h20}};
    cnt = (order.size() > 4) ? 4 : order.size();
    ovf = (order.size() > 4);
    for (int d = 0; d < cnt; d++) dig[d*8 +: 8] = tbl[order[d]*8 +: 8];
  endfunction

  task automatic start_pulse(input logic [4:0] mv);
    @(negedge clk);
    moves = mv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edges counted after the edge that sampled start; moves is scrambled once LOAD is over.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (ready_m !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) moves = ~moves;
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] e_dig_m, e_dig_l;
    int          e_cnt_m, e_cnt_l;
    bit          e_ovf_m, e_ovf_l;
    bit          seen_ready;
    logic [4:0]  mv;

    tv[0] = '{5'b10101, 1'b0, 32'h20_63_6C_72, 3, 1'b0};
    tv[1] = '{5'b11111, 1'b0, 32'h75_6C_64_72, 4, 1'b1};
    tv[2] = '{5'b00000, 1'b0, 32'h20_20_20_20, 0, 1'b0};
    tv[3] = '{5'b00011, 1'b1, 32'h20_20_75_63, 2, 1'b0};
    tv[4] = '{5'b00000, 1'b1, 32'h20_20_20_20, 0, 1'b0};
    tv[5] = '{5'b11111, 1'b1, 32'h64_6C_75_63, 4, 1'b1};
    tv[6] = '{5'b10000, 1'b0, 32'h20_20_20_72, 1, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    moves = '0;
    char_table = DEF_TABLE;
    #12;
    chk("reset_digits", ssd_m, 32'h20202020);
    chk("reset_ready", 32'(ready_m), 32'd0);
    chk("reset_busy", 32'(busy_m), 32'd0);
    chk("reset_ovf", 32'(ovf_m), 32'd0);
    chk("reset_count", 32'(cnt_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_ready", 32'(ready_m), 32'd0);

    for (int t = 0; t < 7; t++) begin
      start_pulse(tv[t].mv);
      chk("busy_after_start", 32'(busy_m), 32'd1);
      wait_ready(lat);
      chk("latency", 32'(lat), 32'd6);
      if (tv[t].lsb) begin
        chk("tbl_lsb_ready", 32'(ready_l), 32'd1);
        chk("tbl_lsb_digits", ssd_l, tv[t].dig);
        chk("tbl_lsb_count", 32'(cnt_l), 32'(tv[t].cnt));
        chk("tbl_lsb_ovf", 32'(ovf_l), 32'(tv[t].ovf));
        chk("tbl_lsb_busy", 32'(busy_l), 32'd0);
      end else begin
        chk("tbl_msb_digits", ssd_m, tv[t].dig);
        chk("tbl_msb_count", 32'(cnt_m), 32'(tv[t].cnt));
        chk("tbl_msb_ovf", 32'(ovf_m), 32'(tv[t].ovf));
        chk("tbl_msb_busy", 32'(busy_m), 32'd0);
      end
      if (t == 0) begin
        repeat (3) @(posedge clk);
        #1;
        chk("hold_ready", 32'(ready_m), 32'd1);
        chk("hold_digits", ssd_m, 32'h20_63_6C_72);
      end
    end

    // Restart during the second SHIFT cycle.
    start_pulse(5'b10101);
    repeat (2) @(posedge clk);
    start_pulse(5'b01000);
    chk("restart_ready_low", 32'(ready_m), 32'd0);
    wait_ready(lat);
    chk("restart_latency", 32'(lat), 32'd6);
    chk("restart_digits", ssd_m, 32'h20_20_20_64);
    chk("restart_count", 32'(cnt_m), 32'd1);

    // Start landing on the final SHIFT edge: no DONE for the aborted encode.
    start_pulse(5'b11111);
    repeat (4) @(posedge clk);
    start_pulse(5'b00010);
    wait_ready(lat);
    chk("final_shift_restart_latency", 32'(lat), 32'd6);
    chk("final_shift_restart_digits", ssd_m, 32'h20_20_20_75);
    chk("final_shift_restart_ovf", 32'(ovf_m), 32'd0);

    // Asynchronous reset in the middle of shifting.
    start_pulse(5'b11111);
    repeat (2) @(posedge clk);
    #1 chk("midshift_busy", 32'(busy_m), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_digits", ssd_m, 32'h20202020);
    chk("async_rst_busy", 32'(busy_m), 32'd0);
    chk("async_rst_count", 32'(cnt_m), 32'd0);
    chk("async_rst_ready", 32'(ready_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (ready_m === 1'b1 || ready_l === 1'b1) seen_ready = 1'b1;
    end
    chk("post_rst_no_ready", 32'(seen_ready), 32'd0);
    chk("post_rst_digits", ssd_m, 32'h20202020);

    // Random moves and tables against the reference model, both priority orders.
    for (int it = 0; it < 40; it++) begin
      char_table = {8'($urandom), 32'($urandom)};
      mv = 5'($urandom);
      model(mv, char_table, 1'b1, e_dig_m, e_cnt_m, e_ovf_m);
      model(mv, char_table, 1'b0, e_dig_l, e_cnt_l, e_ovf_l);
      start_pulse(mv);
      wait_ready(lat);
      chk("rnd_latency", 32'(lat), 32'd6);
      chk("rnd_lsb_ready", 32'(ready_l), 32'd1);
      chk("rnd_msb_digits", ssd_m, e_dig_m);
      chk("rnd_msb_count", 32'(cnt_m), 32'(e_cnt_m));
      chk("rnd_msb_ovf", 32'(ovf_m), 32'(e_ovf_m));
      chk("rnd_lsb_digits", ssd_l, e_dig_l);
      chk("rnd_lsb_count", 32'(cnt_l), 32'(e_cnt_l));
      chk("rnd_lsb_ovf", 32'(ovf_l), 32'(e_ovf_l));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
